// File: rtl/axis_packet_framer.sv
// axis_packet_framer: cuts an AXI4-Stream into fixed-length packets with TLAST,
// optionally prefixed by a header beat carrying a packet sequence number.
module axis_packet_framer #(
  parameter int    AXIS_TDATA_WIDTH = 32,
  parameter int    CNTR_WIDTH       = 32,
  parameter int    PCKT_WIDTH       = 16,
  parameter string HEADER           = "FALSE",
  parameter string ALWAYS_READY     = "FALSE"
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_enable,
  input  logic [CNTR_WIDTH-1:0]       cfg_length,
  input  logic [PCKT_WIDTH-1:0]       cfg_count,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [PCKT_WIDTH-1:0]       sts_packets,
  output logic                        sts_busy,
  output logic                        sts_done
);
  localparam bit HDR = HEADER == "TRUE";
  localparam bit AR  = ALWAYS_READY == "TRUE";
  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_DONE} state_t;
  state_t state_q, state_d;
  logic [CNTR_WIDTH-1:0] beat_q, beat_d, len_q, len_d;
  logic [PCKT_WIDTH-1:0] seq_q, seq_d, pkts_q, pkts_d, cnt_q, cnt_d;
  logic start, acc, last;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      seq_q   <= '0;
      pkts_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      seq_q   <= seq_d;
      pkts_q  <= pkts_d;
      cnt_q   <= cnt_d;
    end
  assign start = cfg_enable && cfg_length != '0 && (cfg_count == '0 || pkts_q < cfg_count);
  assign acc   = state_q == S_PAYLOAD && s_axis_tvalid && m_axis_tready;
  assign last  = beat_q == len_q - CNTR_WIDTH'(1);
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
    seq_d   = seq_q;
    pkts_d  = pkts_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        len_d   = cfg_length;
        cnt_d   = cfg_count;
        beat_d  = '0;
        state_d = HDR ? S_HEADER : S_PAYLOAD;
      end
      S_HEADER: if (m_axis_tready) state_d = S_PAYLOAD;
      S_PAYLOAD: if (acc) begin
        beat_d = last ? '0 : beat_q + CNTR_WIDTH'(1);
        if (last) begin
          seq_d   = seq_q + PCKT_WIDTH'(1);
          pkts_d  = pkts_q + PCKT_WIDTH'(1);
          state_d = cnt_q != '0 && pkts_d == cnt_q ? S_DONE : S_IDLE;
        end
      end
      default: if (!cfg_enable) begin
        pkts_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end
  // header carries the sequence number, truncated or zero-extended to the bus width
  assign s_axis_tready = AR || (state_q == S_PAYLOAD && m_axis_tready);
  assign m_axis_tvalid = state_q == S_HEADER || (state_q == S_PAYLOAD && s_axis_tvalid);
  assign m_axis_tdata  = state_q == S_HEADER ? AXIS_TDATA_WIDTH'(seq_q) :
                         state_q == S_PAYLOAD ? s_axis_tdata : '0;
  assign m_axis_tlast  = state_q == S_PAYLOAD && last;
  assign sts_packets   = pkts_q;
  assign sts_busy      = state_q == S_HEADER || state_q == S_PAYLOAD;
  assign sts_done      = state_q == S_DONE;
endmodule

// File: tb/tb_axis_packet_framer.sv
// tb_axis_packet_framer: three framer configurations against a slot-based packet model.
module tb_axis_packet_framer;
  localparam int TDW [3] = '{16, 16, 8};
  localparam int PW  [3] = '{4, 4, 12};
  localparam bit HD  [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit ARD [3] = '{1'b0, 1'b0, 1'b1};
  localparam int L = 1 << 16;
  logic clk = 0, rst_n = 0, en = 0, sv = 0, mr = 0;
  logic [7:0] len = 0;
  logic [11:0] cnt = 0;
  logic [15:0] sd [3];
  logic [2:0] s_rdy, mv, ml, bz, dn;
  logic [15:0] md0, md1;
  logic [7:0] md2;
  logic [3:0] pk0, pk1;
  logic [11:0] pk2;
  int total = 0, bad = 0;
  int pos [3], seq [3], mpk [3], mlen [3], mcnt [3];
  bit mdn [3];
  bit acc_s [3];
  int q [3][$];
  int ex [$];

  axis_packet_framer #(.AXIS_TDATA_WIDTH(16), .CNTR_WIDTH(8), .PCKT_WIDTH(4), .HEADER("TRUE"), .ALWAYS_READY("FALSE")) u_a (
    .aclk(clk), .aresetn(rst_n), .cfg_enable(en), .cfg_length(len), .cfg_count(cnt[3:0]),
    .s_axis_tready(s_rdy[0]), .s_axis_tdata(sd[0]), .s_axis_tvalid(sv), .m_axis_tready(mr),
    .m_axis_tdata(md0), .m_axis_tvalid(mv[0]), .m_axis_tlast(ml[0]),
    .sts_packets(pk0), .sts_busy(bz[0]), .sts_done(dn[0]));
  axis_packet_framer #(.AXIS_TDATA_WIDTH(16), .CNTR_WIDTH(8), .PCKT_WIDTH(4), .HEADER("FALSE"), .ALWAYS_READY("FALSE")) u_b (
    .aclk(clk), .aresetn(rst_n), .cfg_enable(en), .cfg_length(len), .cfg_count(cnt[3:0]),
    .s_axis_tready(s_rdy[1]), .s_axis_tdata(sd[1]), .s_axis_tvalid(sv), .m_axis_tready(mr),
    .m_axis_tdata(md1), .m_axis_tvalid(mv[1]), .m_axis_tlast(ml[1]),
    .sts_packets(pk1), .sts_busy(bz[1]), .sts_done(dn[1]));
  axis_packet_framer #(.AXIS_TDATA_WIDTH(8), .CNTR_WIDTH(8), .PCKT_WIDTH(12), .HEADER("TRUE"), .ALWAYS_READY("TRUE")) u_c (
    .aclk(clk), .aresetn(rst_n), .cfg_enable(en), .cfg_length(len), .cfg_count(cnt),
    .s_axis_tready(s_rdy[2]), .s_axis_tdata(sd[2][7:0]), .s_axis_tvalid(sv), .m_axis_tready(mr),
    .m_axis_tdata(md2), .m_axis_tvalid(mv[2]), .m_axis_tlast(ml[2]),
    .sts_packets(pk2), .sts_busy(bz[2]), .sts_done(dn[2]));

  initial forever #5 clk = ~clk;

  function automatic int a_data(int i);
    return i == 0 ? int'(md0) : i == 1 ? int'(md1) : int'(md2);
  endfunction
  function automatic int a_pk(int i);
    return i == 0 ? int'(pk0) : i == 1 ? int'(pk1) : int'(pk2);
  endfunction

  task automatic chk(string nm, int i, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d at %0t", nm, i, act, exp, $time);
    end
  endtask

  task automatic chkq(string nm, int i);
    for (int k = 0; k < ex.size(); k++) chk(nm, i, k < q[i].size() ? q[i][k] : -1, ex[k]);
  endtask

  // A packet is a run of slots: slot 0 is the header when present, the rest are payload beats.
  // pos < 0 means no packet in flight; mdn marks a completed burst awaiting enable low.
  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      pos[i] = -1; seq[i] = 0; mpk[i] = 0; mlen[i] = 0; mcnt[i] = 0; mdn[i] = 0;
    end
  endfunction

  function automatic void step(int i);
    int m, ci;
    m = 1 << PW[i];
    ci = i < 2 ? int'(cnt[3:0]) : int'(cnt);
    if (pos[i] < 0) begin
      if (mdn[i]) begin
        if (!en) begin mpk[i] = 0; mdn[i] = 0; end
      end else if (en && len != 0 && (ci == 0 || mpk[i] < ci)) begin
        mlen[i] = int'(len); mcnt[i] = ci; pos[i] = 0;
      end
    end else if (HD[i] && pos[i] == 0) begin
      if (mr) pos[i] = 1;
    end else if (sv && mr) begin
      if (pos[i] - int'(HD[i]) == mlen[i] - 1) begin
        seq[i] = (seq[i] + 1) % m;
        mpk[i] = (mpk[i] + 1) % m;
        pos[i] = -1;
        mdn[i] = mcnt[i] != 0 && mpk[i] == mcnt[i];
      end else pos[i]++;
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      acc_s[i] = sv && s_rdy[i];
      if (mv[i] && mr) q[i].push_back(a_data(i) | (ml[i] ? L : 0));
    end
    @(posedge clk);
    if (rst_n) for (int i = 0; i < 3; i++) step(i);
    #1;
    for (int i = 0; i < 3; i++) if (acc_s[i]) sd[i] = sd[i] + 16'd1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < 3; i++) begin q[i].delete(); sd[i] = 0; end
  endtask

  task automatic reset_dut();
    rst_n = 0;
    model_reset();
    tick(); tick();
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    bit hs, py;
    int dm;
    for (int i = 0; i < 3; i++) begin
      hs = HD[i] && pos[i] == 0;
      py = pos[i] >= 0 && !hs;
      dm = (1 << TDW[i]) - 1;
      chk("tready", i, int'(s_rdy[i]), int'(ARD[i] || (py && mr)));
      chk("tvalid", i, int'(mv[i]), int'(hs || (py && sv)));
      chk("tdata", i, a_data(i), hs ? (seq[i] & dm) : py ? (int'(sd[i]) & dm) : 0);
      chk("tlast", i, int'(ml[i]), int'(py && pos[i] - int'(HD[i]) == mlen[i] - 1));
      chk("busy", i, int'(bz[i]), int'(pos[i] >= 0));
      chk("done", i, int'(dn[i]), int'(mdn[i]));
      chk("packets", i, a_pk(i), mpk[i]);
    end
  end

  initial begin
    model_reset();
    for (int i = 0; i < 3; i++) sd[i] = 0;
    reset_dut();
    chk("rst_tready", 0, int'(s_rdy), 4);
    chk("rst_tvalid", 0, int'(mv), 0);
    chk("rst_busy", 0, int'(bz), 0);
    chk("rst_pk", 0, a_pk(0), 0);
    // burst of two 3-beat packets
    clear_src();
    en = 1; len = 3; cnt = 2; sv = 1; mr = 1;
    repeat (12) tick();
    ex = '{0, 0, 1, 2 | L, 1, 3, 4, 5 | L};
    chkq("burst_hdr", 0);
    ex = '{0, 1, 2 | L, 3, 4, 5 | L};
    chkq("burst_plain", 1);
    ex = '{0, 2, 3, 4 | L, 1, 7, 8, 9 | L};
    chkq("burst_drop", 2);
    chk("burst_done", 0, int'(dn), 7);
    chk("burst_pk", 0, a_pk(0), 2);
    chk("burst_pk", 2, a_pk(2), 2);
    chk("burst_tready", 0, int'(s_rdy[0]), 0);
    chk("burst_tready", 2, int'(s_rdy[2]), 1);
    en = 0;
    repeat (2) tick();
    chk("dis_pk", 0, a_pk(0), 0);
    chk("dis_done", 0, int'(dn), 0);
    for (int i = 0; i < 3; i++) q[i].delete();
    en = 1;
    repeat (4) tick();
    chk("reen_seq", 0, q[0].size() > 0 ? q[0][0] : -1, 2);
    chk("reen_seq", 2, q[2].size() > 0 ? q[2][0] : -1, 2);
    // asynchronous reset in the middle of a payload
    reset_dut();
    clear_src();
    en = 1; len = 4; cnt = 0;
    repeat (3) tick();
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("mid_tvalid", 0, int'(mv), 0);
    chk("mid_tlast", 0, int'(ml), 0);
    chk("mid_busy", 0, int'(bz), 0);
    chk("mid_tready", 0, int'(s_rdy), 4);
    chk("mid_tdata", 1, a_data(1), 0);
    tick(); tick();
    rst_n = 1;
    clear_src();
    repeat (8) tick();
    ex = '{0, 0, 1, 2, 3 | L};
    chkq("post_rst", 0);
    // enable dropped two beats into an 8-beat packet
    reset_dut();
    clear_src();
    en = 1; len = 8; cnt = 0;
    repeat (3) tick();
    en = 0;
    repeat (15) tick();
    ex = '{0, 1, 2, 3, 4, 5, 6, 7 | L};
    chkq("drop_en", 1);
    chk("drop_en_n", 1, q[1].size(), 8);
    chk("drop_en_n", 0, q[0].size(), 9);
    // downstream ready toggling every cycle
    en = 1; len = 5; cnt = 0;
    repeat (40) begin mr = ~mr; tick(); end
    // random traffic and configuration
    for (int c = 0; c < 3000; c++) begin
      sv = $urandom_range(0, 3) != 0;
      mr = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 29) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) begin
        len = 8'($urandom_range(0, 6));
        cnt = 12'($urandom_range(0, 3));
      end
      if (c == 1500) reset_dut();
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
